// File: rtl/burst_formatter.sv
// burst_formatter: buffers one GSM normal burst payload and emits a
// 156-symbol differentially-encoded burst to the GMSK modulator.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start_load          pulse, begins payload capture (IDLE only)
//   tsc                 training sequence index, sampled on start_load
//   steal_hl, steal_hu  stealing flags, sampled on start_load
//   data_bit/valid      payload stream, accepted while data_ready
//   data_ready          LOAD and fewer than NUM_DATA bits captured
//   armed               buffer full, burst may be fired
//   fire_burst          starts the burst (ARMED only)
//   symbol_input_strobe modulator request, rising edge advances
//   current_symbol      registered symbol, 1 between bursts
//   burst_active        fire until last guard symbol consumed
//   burst_done          one-cycle pulse at end of burst

module burst_formatter #(
  parameter int NUM_DATA   = 114,
  parameter int GUARD_SYMS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_load,
  input  logic [2:0] tsc,
  input  logic       steal_hl,
  input  logic       steal_hu,
  input  logic       data_bit,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       armed,
  input  logic       fire_burst,
  input  logic       symbol_input_strobe,
  output logic       current_symbol,
  output logic       burst_active,
  output logic       burst_done
);

  localparam int HALF    = NUM_DATA / 2;
  localparam int TSC_LEN = 26;
  localparam int N_SYMS  = 3 + HALF + 1 + TSC_LEN + 1 + HALF + 3
                         + GUARD_SYMS;
  localparam int CW      = $clog2(NUM_DATA + 1);
  localparam int IW      = $clog2(NUM_DATA);
  localparam int NW      = $clog2(N_SYMS + 1);

  // Symbol index landmarks within the burst
  localparam int D0 = 3;
  localparam int D1 = D0 + HALF;
  localparam int T0 = D1 + 1;
  localparam int HU = T0 + TSC_LEN;
  localparam int D2 = HU + 1;
  localparam int DE = D2 + HALF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [NW-1:0]       n_q;
  logic [NUM_DATA-1:0] buf_q;
  logic [2:0]          tsc_idx_q;
  logic [TSC_LEN-1:0]  tsc_word_q;
  logic                hl_q;
  logic                hu_q;
  logic                strobe_q;
  logic                bprev_q;
  logic                sym_q;
  logic                ready_q;
  logic                armed_q;
  logic                active_q;
  logic                done_q;

  logic                beat;
  logic                strobe_edge;
  logic                raw_b;
  logic [IW-1:0]       a_off;
  logic [IW-1:0]       b_off;
  logic [4:0]          t_off;

  // Training sequences, first transmitted bit in the MSB
  function automatic logic [TSC_LEN-1:0] tsc_rom(
    input logic [2:0] idx
  );
    logic [TSC_LEN-1:0] w;
    case (idx)
      3'd0:    w = 26'b00100101110000100010010111;
      3'd1:    w = 26'b00101101110111100010110111;
      3'd2:    w = 26'b01000011101110100100001110;
      3'd3:    w = 26'b01000111101101000100011110;
      3'd4:    w = 26'b00011010111001000001101011;
      3'd5:    w = 26'b01001110101100000100111010;
      3'd6:    w = 26'b10100111110110001010011111;
      3'd7:    w = 26'b11101111000100101110111100;
      default: w = '0;
    endcase
    return w;
  endfunction

  assign beat        = data_valid & ready_q;
  assign strobe_edge = symbol_input_strobe & ~strobe_q;

  // Raw (pre-encoding) bit for the symbol index held in n_q
  always_comb begin
    raw_b = 1'b0;
    a_off = IW'(n_q - NW'(D0));
    b_off = IW'(n_q - NW'(D2 - HALF));
    t_off = 5'(NW'(T0 + TSC_LEN - 1) - n_q);
    if (n_q < NW'(D0)) begin
      raw_b = 1'b0;
    end else if (n_q < NW'(D1)) begin
      raw_b = buf_q[a_off];
    end else if (n_q == NW'(D1)) begin
      raw_b = hl_q;
    end else if (n_q < NW'(HU)) begin
      raw_b = tsc_word_q[t_off];
    end else if (n_q == NW'(HU)) begin
      raw_b = hu_q;
    end else if (n_q < NW'(DE)) begin
      raw_b = buf_q[b_off];
    end else begin
      raw_b = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      tsc_idx_q  <= '0;
      tsc_word_q <= '0;
      hl_q       <= 1'b0;
      hu_q       <= 1'b0;
      strobe_q   <= 1'b0;
      bprev_q    <= 1'b1;
      sym_q      <= 1'b1;
      ready_q    <= 1'b0;
      armed_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      strobe_q <= symbol_input_strobe;
      done_q   <= 1'b0;
      if (beat) begin
        buf_q[IW'(cnt_q)] <= data_bit;
      end
      case (state_q)
        S_IDLE: begin
          if (start_load) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            tsc_idx_q <= tsc;
            hl_q      <= steal_hl;
            hu_q      <= steal_hu;
          end
        end
        S_LOAD: begin
          tsc_word_q <= tsc_rom(tsc_idx_q);
          if (beat) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(NUM_DATA - 1)) begin
              ready_q <= 1'b0;
              armed_q <= 1'b1;
              state_q <= S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (fire_burst) begin
            armed_q  <= 1'b0;
            active_q <= 1'b1;
            bprev_q  <= 1'b1;
            n_q      <= '0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT, S_EMIT: begin
          if (strobe_edge) begin
            if (n_q == NW'(N_SYMS)) begin
              // Edge after the last guard symbol closes the burst
              state_q  <= S_IDLE;
              sym_q    <= 1'b1;
              active_q <= 1'b0;
              done_q   <= 1'b1;
              n_q      <= '0;
              bprev_q  <= 1'b1;
            end else begin
              sym_q   <= ~(raw_b ^ bprev_q);
              bprev_q <= raw_b;
              n_q     <= n_q + NW'(1);
              state_q <= S_EMIT;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_ready     = ready_q;
  assign armed          = armed_q;
  assign current_symbol = sym_q;
  assign burst_active   = active_q;
  assign burst_done     = done_q;

endmodule

// File: tb/tb_burst_formatter.sv
// tb_burst_formatter: directed bench for burst_formatter with a
// queue-based burst model and a per-cycle compare process.

module tb_burst_formatter;

  localparam int ND = 114;
  localparam int NS = 156;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_load;
  logic [2:0] tsc;
  logic       steal_hl;
  logic       steal_hu;
  logic       data_bit;
  logic       data_valid;
  logic       data_ready;
  logic       armed;
  logic       fire_burst;
  logic       symbol_input_strobe;
  logic       current_symbol;
  logic       burst_active;
  logic       burst_done;

  always #5 clock = ~clock;

  burst_formatter dut (
    .clock               (clock),
    .reset               (reset),
    .start_load          (start_load),
    .tsc                 (tsc),
    .steal_hl            (steal_hl),
    .steal_hu            (steal_hu),
    .data_bit            (data_bit),
    .data_valid          (data_valid),
    .data_ready          (data_ready),
    .armed               (armed),
    .fire_burst          (fire_burst),
    .symbol_input_strobe (symbol_input_strobe),
    .current_symbol      (current_symbol),
    .burst_active        (burst_active),
    .burst_done          (burst_done)
  );

  logic [25:0] tsc_tab [8] = '{
    26'b00100101110000100010010111,
    26'b00101101110111100010110111,
    26'b01000011101110100100001110,
    26'b01000111101101000100011110,
    26'b00011010111001000001101011,
    26'b01001110101100000100111010,
    26'b10100111110110001010011111,
    26'b11101111000100101110111100
  };

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LOAD, M_ARMED, M_BURST} mph_t;
  mph_t mph;
  int   mbeats;
  int   mk;
  int   mtsc;
  bit   mpay [ND];
  bit   msyms [NS];
  bit   mhl, mhu;
  bit   mprev_str;
  bit   edge_s;
  logic e_sym, e_act, e_done, e_rdy, e_arm;

  function automatic void build_syms();
    bit q[$];
    bit p;
    q = {};
    repeat (3) q.push_back(1'b0);
    for (int i = 0; i < ND / 2; i++) q.push_back(mpay[i]);
    q.push_back(mhl);
    for (int j = 25; j >= 0; j--) q.push_back(tsc_tab[mtsc][j]);
    q.push_back(mhu);
    for (int i = ND / 2; i < ND; i++) q.push_back(mpay[i]);
    repeat (11) q.push_back(1'b0);
    p = 1'b1;
    for (int k = 0; k < NS; k++) begin
      msyms[k] = ~(q[k] ^ p);
      p = q[k];
    end
  endfunction

  always @(posedge clock) begin
    edge_s = symbol_input_strobe && !mprev_str;
    if (reset) begin
      mph = M_IDLE;
      mprev_str = 1'b0;
      e_sym = 1'b1; e_act = 1'b0; e_done = 1'b0;
      e_rdy = 1'b0; e_arm = 1'b0;
    end else begin
      mprev_str = symbol_input_strobe;
      e_done = 1'b0;
      case (mph)
        M_IDLE: if (start_load) begin
          mph = M_LOAD; mbeats = 0; e_rdy = 1'b1;
          mtsc = int'(tsc); mhl = steal_hl; mhu = steal_hu;
        end
        M_LOAD: if (data_valid && e_rdy) begin
          mpay[mbeats] = data_bit;
          mbeats++;
          if (mbeats == ND) begin
            e_rdy = 1'b0; e_arm = 1'b1; mph = M_ARMED;
          end
        end
        M_ARMED: if (fire_burst) begin
          e_arm = 1'b0; e_act = 1'b1; build_syms(); mk = 0;
          mph = M_BURST;
        end
        M_BURST: if (edge_s) begin
          if (mk < NS) begin
            e_sym = msyms[mk]; mk++;
          end else begin
            mph = M_IDLE; e_sym = 1'b1; e_act = 1'b0; e_done = 1'b1;
          end
        end
        default: mph = M_IDLE;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("current_symbol", current_symbol, e_sym);
      chk("burst_active", burst_active, e_act);
      chk("burst_done", burst_done, e_done);
      chk("data_ready", data_ready, e_rdy);
      chk("armed", armed, e_arm);
    end
    if (burst_done === 1'b1) done_cnt++;
  end

  // ---------------- driver ----------------
  bit   dpay [ND];
  logic slog [NS];

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input logic [2:0] t, input bit hl,
                         input bit hu, input bit bp,
                         input bit fire_mid);
    int i;
    int cyc;
    start_load = 1'b1; tsc = t; steal_hl = hl; steal_hu = hu;
    tick(1);
    start_load = 1'b0;
    i = 0; cyc = 0;
    while (i < ND) begin
      data_bit   = dpay[i];
      data_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      fire_burst = fire_mid && (cyc == 20);
      tick(1);
      if (data_valid) i++;
      cyc++;
    end
    data_valid = 1'b0; fire_burst = 1'b0;
  endtask

  task automatic do_fire();
    fire_burst = 1'b1;
    tick(1);
    fire_burst = 1'b0;
    chk("active_after_fire", burst_active, 1);
  endtask

  task automatic run_strobes(input int cnt, input int hold,
                             input int gap);
    for (int k = 0; k < cnt; k++) begin
      symbol_input_strobe = 1'b1;
      tick(1);
      if (k < NS) slog[k] = current_symbol;
      tick(hold - 1);
      symbol_input_strobe = 1'b0;
      tick(gap);
    end
  endtask

  task automatic check_zero_log(input string tag);
    logic [5:0] pat;
    pat = 6'b110010;
    chk({tag, "_s0"}, slog[0], 0);
    for (int k = 1; k <= 60; k++)
      chk($sformatf("%s_s%0d", tag, k), slog[k], 1);
    for (int j = 0; j < 6; j++)
      chk($sformatf("%s_s%0d", tag, 61 + j), slog[61 + j], pat[5 - j]);
  endtask

  initial begin
    reset = 1'b1; start_load = 1'b0; tsc = 3'd0;
    steal_hl = 1'b0; steal_hu = 1'b0; data_bit = 1'b0;
    data_valid = 1'b0; fire_burst = 1'b0;
    symbol_input_strobe = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    reset = 1'b0;

    // reset values, idle strobes and fire ignored
    chk("rst_sym", current_symbol, 1);
    chk("rst_ready", data_ready, 0);
    chk("rst_armed", armed, 0);
    chk("rst_active", burst_active, 0);
    chk("rst_done", burst_done, 0);
    run_strobes(3, 1, 1);
    fire_burst = 1'b1; tick(1); fire_burst = 1'b0;
    chk("idle_sym", current_symbol, 1);
    chk("idle_active", burst_active, 0);

    // all-zero burst with back-pressure
    for (int i = 0; i < ND; i++) dpay[i] = 1'b0;
    do_load(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("armed_after_load", armed, 1);
    chk("ready_after_load", data_ready, 0);
    data_valid = 1'b1; data_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("ready_overflow", data_ready, 0);
    end
    data_valid = 1'b0;
    start_load = 1'b1; tick(1); start_load = 1'b0;
    chk("armed_hold", armed, 1);
    do_fire();
    chk("armed_cleared", armed, 0);
    run_strobes(157, 1, 1);
    tick(3);
    check_zero_log("zero");
    chk("done_cnt_zero", done_cnt, 1);

    // held strobe
    do_load(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fire();
    run_strobes(157, 4, 2);
    tick(3);
    check_zero_log("held");
    chk("done_cnt_held", done_cnt, 2);

    // flags and payload, fire during LOAD ignored
    dpay[0] = 1'b1;
    do_load(3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_fire();
    run_strobes(157, 1, 1);
    tick(3);
    chk("flag_s3", slog[3], 0);
    chk("flag_s4", slog[4], 0);
    chk("flag_s60", slog[60], 0);
    chk("done_cnt_flag", done_cnt, 3);

    // random payload, other training sequence, upper flag
    for (int i = 0; i < ND; i++) dpay[i] = 1'($urandom_range(0, 1));
    do_load(3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    do_fire();
    run_strobes(157, 2, 1);
    tick(3);
    chk("done_cnt_rand", done_cnt, 4);

    // reset mid-burst, then a clean burst
    for (int i = 0; i < ND; i++) dpay[i] = 1'b0;
    do_load(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fire();
    run_strobes(81, 1, 1);
    reset = 1'b1;
    tick(1);
    chk("midrst_sym", current_symbol, 1);
    chk("midrst_active", burst_active, 0);
    chk("midrst_done", burst_done, 0);
    reset = 1'b0;
    tick(2);
    chk("done_cnt_midrst", done_cnt, 4);
    do_load(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fire();
    run_strobes(157, 1, 1);
    tick(3);
    check_zero_log("after_rst");
    chk("done_cnt_final", done_cnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/burst_formatter.md
# burst_formatter

Upstream feeder for the GMSK transmit chain. It buffers one GSM normal burst's 114 payload bits and appends the two stealing flags. It then emits a 156-symbol burst, one differentially-encoded symbol per modulator `symbol_input_strobe` edge. The burst layout is 3 tail, 57 data, 1 flag, 26 training, 1 flag, 57 data, 3 tail, 8 guard. Its output `current_symbol` drives the modulator symbol input directly. Between bursts it holds `current_symbol` at 1, which matches the modulator priming level.

## Interface
- `NUM_DATA`, 114: payload bits per burst.
- `GUARD_SYMS`, 8: guard symbols appended after the trailing tail.
- `TSC_FILE`, "air_interface/gen/tsc.hex": 8 words × 26 bits, MSB = first transmitted bit.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start_load`  in  1  one-cycle pulse that begins payload capture; accepted in IDLE only.
- `tsc`  in  3  training sequence index; sampled on `start_load`.
- `steal_hl`, `steal_hu`  in  1 each  stealing flags; sampled on `start_load`.
- `data_bit`  in  1  payload bit.
- `data_valid`  in  1  `data_bit` is valid.
- `data_ready`  out  1  high in LOAD while fewer than `NUM_DATA` bits are captured.
- `armed`  out  1  the buffer is full and a burst may be fired.
- `fire_burst`  in  1  begins the burst; accepted in ARMED only.
- `symbol_input_strobe`  in  1  modulator request; may be high for several cycles.
- `current_symbol`  out  1  registered symbol to the modulator.
- `burst_active`  out  1  high from fire until the last guard symbol has been consumed.
- `burst_done`  out  1  one-cycle pulse at the end of a burst.

## Operation
- **States:** IDLE → LOAD → ARMED → WAIT_FIRST → EMIT → IDLE.
  - IDLE → LOAD: `start_load`.
  - LOAD → ARMED: the 114th beat.
  - ARMED → WAIT_FIRST: `fire_burst`.
  - WAIT_FIRST → EMIT: first strobe edge.
  - EMIT → IDLE: the strobe edge after symbol index 155.
- **Capture:**
  - A beat is `data_valid & data_ready`.
  - Beat k stores `data_bit` in `buf[k]` (k = 0..113).
  - A 7-bit counter tracks beats and is cleared on `start_load`.
- **TSC:** `tsc_word` is loaded from the ROM at index `tsc` in the cycle after `start_load`.
- **Strobe edge:** `edge = symbol_input_strobe & ~strobe_q`.
  - `strobe_q` is registered every cycle.
  - A held strobe yields exactly one advance.
- **Symbol index n (0..155)** gives raw bit b:
  - n = 0–2: 0
  - n = 3–59: `buf[n-3]`
  - n = 60: `steal_hl`
  - n = 61–86: `tsc_word[25-(n-61)]`
  - n = 87: `steal_hu`
  - n = 88–144: `buf[n-31]`
  - n = 145–147: 0
  - n = 148–155: 0 (guard)
- **Differential encoding:**
  - `current_symbol = ~(b_n ^ b_prev)`.
  - `b_prev` is preset to 1 on fire and updated to `b_n` after each symbol.
- **Outside EMIT/WAIT_FIRST:** `current_symbol = 1`.
- **Ignored inputs:**
  - `fire_burst` outside ARMED.
  - `start_load` outside IDLE.
  - Strobe edges in IDLE, LOAD and ARMED.
- **Simultaneous start_load and data_valid in IDLE:** the beat is not captured, because `data_ready` is 0 in IDLE.
- **Reset, including mid-burst or mid-load:**
  - state = IDLE, n = 0, counter = 0, `b_prev` = 1.
  - `current_symbol` = 1; `armed`, `data_ready`, `burst_active`, `burst_done` all = 0.
  - `strobe_q` = 0.
  - Buffer contents are don't-care.

## Timing
- `data_ready` rises in the cycle after `start_load`.
- `data_ready` falls in the cycle after the 114th beat.
- `armed` rises in that same cycle and stays high until the cycle after `fire_burst`.
- `burst_active` rises the cycle after `fire_burst` is accepted.
- **Symbol latency:**
  - Edge detected in cycle t → `current_symbol` valid from t+1 until the next edge.
  - The first edge after fire produces symbol 0.
  - The 156th edge produces symbol 155.
- **End of burst:**
  - The 157th edge returns the block to IDLE: `current_symbol` = 1, `burst_active` = 0, `burst_done` = 1, all from t+1.
  - `burst_done` is 0 from t+2.
- **Throughput:** at most one symbol per edge; edges closer than 2 cycles apart are not required.
- The buffer is unchanged by a burst, but a new `start_load` is required to re-arm.

## Test plan
- **Reset values:** assert `reset` for 2 cycles → `current_symbol` = 1, all other outputs 0; strobe edges in IDLE leave `current_symbol` at 1.
- **All-zero burst:**
  - Setup: payload all 0, `tsc` = 0 (ROM word 26'b00100101110000100010010111), flags 0, fire, 157 strobes.
  - Symbols 0–60: 0, then 1 ×60.
  - Symbols 61–66: 1,1,0,0,1,0.
  - `burst_done` pulses exactly once, after edge 157.
- **Back-pressure:**
  - Toggle `data_valid` with a random pattern → exactly 114 beats captured, `armed` goes high.
  - A 115th valid bit is not accepted (`data_ready` = 0).
- **Held strobe:** hold `symbol_input_strobe` high for 4 cycles per symbol → one symbol per strobe, same sequence as the all-zero burst.
- **Flags and payload:**
  - Setup: payload `buf[0]` = 1, rest 0; `steal_hl` = 1.
  - Symbols 3 and 4 = 0,0; symbol 60 = 0.
  - Fire while still in LOAD is ignored.
- **Reset mid-burst:**
  - Assert `reset` at symbol 80 → next cycle IDLE, `current_symbol` = 1, no `burst_done`.
  - A full reload and fire then reproduces the all-zero burst sequence.
